// File: rtl/tinyml_display_window_stream.sv
// Display back end: H/V timing generator, pixel FIFO and a runtime-placed
// image window. Outside the window, and on underflow, a background colour
// is driven. Frame alignment is tracked with in_sof; on underflow or a
// misplaced sof the FIFO is flushed and the block resynchronises.
module tinyml_display_window_stream #(
  parameter int PPC          = 2,
  parameter int BPC          = 8,
  parameter int H_SYNC       = 50,
  parameter int H_BP         = 50,
  parameter int H_ACTIVE     = 540,
  parameter int H_FP         = 100,
  parameter int V_SYNC       = 3,
  parameter int V_BP         = 5,
  parameter int V_ACTIVE     = 1920,
  parameter int V_FP         = 6,
  parameter int FIFO_DEPTH   = 1024,
  parameter int START_THRESH = 512,
  parameter logic [3*BPC-1:0] BG_COLOR = 24'hFFFFFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [11:0]                   cfg_win_x,
  input  logic [11:0]                   cfg_win_y,
  input  logic [11:0]                   cfg_win_w,
  input  logic [11:0]                   cfg_win_h,
  input  logic                          cfg_blank,
  input  logic [PPC*3*BPC-1:0]          in_data,
  input  logic                          in_sof,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out_hs,
  output logic                          out_vs,
  output logic                          out_de,
  output logic [PPC*3*BPC-1:0]          out_data,
  output logic [15:0]                   frame_cnt,
  output logic [1:0]                    stat_state,
  output logic [$clog2(FIFO_DEPTH):0]   stat_fifo_level,
  output logic [15:0]                   stat_underflow_cnt,
  output logic [15:0]                   stat_misalign_cnt
);

  localparam int DW      = PPC * 3 * BPC;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;
  localparam int LINE    = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int FRAME   = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;

  localparam logic [1:0] ST_SEEK = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // timing counters
  logic [12:0] h_cnt_reg, v_cnt_reg;
  // frame-start shadow copies of the configuration
  logic [11:0] win_x_reg, win_y_reg, win_w_reg, win_h_reg;
  logic        blank_reg;
  // FSM and FIFO bookkeeping
  logic [1:0]  state_reg, state_next;
  logic        first_win_reg;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
  logic [LW-1:0] level_reg, level_next;
  logic [FIFO_DEPTH-1:0] sof_bits_reg;
  logic [DW-1:0] mem [0:FIFO_DEPTH-1];
  logic [DW-1:0] rd_data_reg;
  // pipeline stage 1 and output stage
  logic hs1_reg, vs1_reg, de1_reg, blank1_reg, sel1_reg;
  logic out_hs_reg, out_vs_reg, out_de_reg;
  logic [DW-1:0] out_data_reg;
  logic [15:0] frame_cnt_reg, underflow_cnt_reg, misalign_cnt_reg;

  // background beat: BG_COLOR replicated into every pixel lane
  logic [DW-1:0] bg_beat;
  genvar gi;
  generate
    for (gi = 0; gi < PPC; gi++) begin : g_bg
      assign bg_beat[gi*3*BPC +: 3*BPC] = BG_COLOR;
    end
  endgenerate

  // stage-0 decode of the raw counters
  logic        hs0, vs0, de0, fs, win0, last_px;
  logic [12:0] x0, y0;
  assign hs0 = h_cnt_reg < 13'(H_SYNC);
  assign vs0 = v_cnt_reg < 13'(V_SYNC);
  assign de0 = (h_cnt_reg >= 13'(H_START)) && (h_cnt_reg < 13'(H_START + H_ACTIVE)) &&
               (v_cnt_reg >= 13'(V_START)) && (v_cnt_reg < 13'(V_START + V_ACTIVE));
  assign x0  = h_cnt_reg - 13'(H_START);
  assign y0  = v_cnt_reg - 13'(V_START);
  assign fs  = (h_cnt_reg == 13'd0) && (v_cnt_reg == 13'd0);
  // 13-bit window compare so origin+size never wraps
  assign win0 = de0 &&
                (x0 >= {1'b0, win_x_reg}) && (x0 < ({1'b0, win_x_reg} + {1'b0, win_w_reg})) &&
                (y0 >= {1'b0, win_y_reg}) && (y0 < ({1'b0, win_y_reg} + {1'b0, win_h_reg}));
  assign last_px = de0 && (x0 == 13'(H_ACTIVE - 1)) && (y0 == 13'(V_ACTIVE - 1));

  // stream / FIFO control
  logic fifo_empty, head_sof, run_win, underflow_ev, misalign_ev, flush, pop, accept, push;
  assign fifo_empty   = (level_reg == '0);
  assign head_sof     = sof_bits_reg[rd_ptr_reg];
  assign run_win      = win0 && (state_reg == ST_RUN);
  assign underflow_ev = run_win && fifo_empty;
  assign misalign_ev  = run_win && !fifo_empty && (head_sof != first_win_reg);
  assign flush        = underflow_ev || misalign_ev;
  assign pop          = run_win && !fifo_empty && !misalign_ev;
  assign in_ready     = !rst && ((state_reg == ST_SEEK) || (level_reg <= LW'(FIFO_DEPTH - 3)));
  assign accept       = in_valid && in_ready;
  // SEEK drops everything up to the sof beat; a write racing a flush is lost
  assign push         = accept && !flush && ((state_reg != ST_SEEK) || in_sof);

  // next-state for FSM, level and pointers
  always_comb begin
    state_next  = state_reg;
    level_next  = level_reg + LW'(push) - LW'(pop);
    wr_ptr_next = wr_ptr_reg + AW'(push);
    rd_ptr_next = rd_ptr_reg + AW'(pop);
    case (state_reg)
      ST_SEEK: if (accept && in_sof) state_next = ST_FILL;
      ST_FILL: if (fs && (level_reg >= LW'(START_THRESH))) state_next = ST_RUN;
      ST_RUN:  if (flush) state_next = ST_SEEK;
      default: state_next = ST_SEEK;
    endcase
    if (flush) begin
      level_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end
  end

  // free-running H/V counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_cnt_reg == 13'(LINE - 1)) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= (v_cnt_reg == 13'(FRAME - 1)) ? 13'd0 : v_cnt_reg + 13'd1;
    end else begin
      h_cnt_reg <= h_cnt_reg + 13'd1;
    end
  end

  // configuration is sampled only at frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_x_reg <= '0;
      win_y_reg <= '0;
      win_w_reg <= '0;
      win_h_reg <= '0;
      blank_reg <= 1'b0;
    end else if (fs) begin
      win_x_reg <= cfg_win_x;
      win_y_reg <= cfg_win_y;
      win_w_reg <= cfg_win_w;
      win_h_reg <= cfg_win_h;
      blank_reg <= cfg_blank;
    end
  end

  // FSM, FIFO pointers/level and the per-beat sof flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_SEEK;
      first_win_reg <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      sof_bits_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      first_win_reg <= fs ? 1'b1 : (win0 ? 1'b0 : first_win_reg);
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      level_reg     <= level_next;
      if (push) sof_bits_reg[wr_ptr_reg] <= in_sof;
    end
  end

  // pixel storage: inferred RAM with registered read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_data;
  end

  // registered read port, advanced only on pop
  always_ff @(posedge clk) begin
    if (pop) rd_data_reg <= mem[rd_ptr_reg];
  end

  // two-stage output pipeline keeps sync, enable and data aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs1_reg      <= 1'b0;
      vs1_reg      <= 1'b0;
      de1_reg      <= 1'b0;
      blank1_reg   <= 1'b0;
      sel1_reg     <= 1'b0;
      out_hs_reg   <= 1'b0;
      out_vs_reg   <= 1'b0;
      out_de_reg   <= 1'b0;
      out_data_reg <= '0;
    end else begin
      hs1_reg      <= hs0;
      vs1_reg      <= vs0;
      de1_reg      <= de0;
      blank1_reg   <= blank_reg;
      sel1_reg     <= pop;
      out_hs_reg   <= hs1_reg;
      out_vs_reg   <= vs1_reg;
      out_de_reg   <= de1_reg;
      out_data_reg <= (!de1_reg || blank1_reg) ? '0 : (sel1_reg ? rd_data_reg : bg_beat);
    end
  end

  // frame counter (wraps) and saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_reg     <= '0;
      underflow_cnt_reg <= '0;
      misalign_cnt_reg  <= '0;
    end else begin
      if (last_px) frame_cnt_reg <= frame_cnt_reg + 16'd1;
      if (underflow_ev && (underflow_cnt_reg != 16'hFFFF))
        underflow_cnt_reg <= underflow_cnt_reg + 16'd1;
      if (misalign_ev && (misalign_cnt_reg != 16'hFFFF))
        misalign_cnt_reg <= misalign_cnt_reg + 16'd1;
    end
  end

  assign out_hs             = out_hs_reg;
  assign out_vs             = out_vs_reg;
  assign out_de             = out_de_reg;
  assign out_data           = out_data_reg;
  assign frame_cnt          = frame_cnt_reg;
  assign stat_state         = state_reg;
  assign stat_fifo_level    = level_reg;
  assign stat_underflow_cnt = underflow_cnt_reg;
  assign stat_misalign_cnt  = misalign_cnt_reg;

endmodule

// File: tb/tb_tinyml_display_window_stream.sv
// Directed bench: small timing (14 clk lines, 7 line frames, 98 clk/frame),
// walks fill/run, window placement, blanking, underflow and misalignment.
module tb_tinyml_display_window_stream;

  localparam int FR = 98;
  localparam logic [47:0] BG2 = 48'hFFFFFF_FFFFFF;

  logic        clk, rst;
  logic [11:0] cfg_win_x, cfg_win_y, cfg_win_w, cfg_win_h;
  logic        cfg_blank;
  logic [47:0] in_data;
  logic        in_sof, in_valid, in_ready;
  logic        out_hs, out_vs, out_de;
  logic [47:0] out_data;
  logic [15:0] frame_cnt;
  logic [1:0]  stat_state;
  logic [6:0]  stat_fifo_level;
  logic [15:0] stat_underflow_cnt, stat_misalign_cnt;

  tinyml_display_window_stream #(
    .PPC(2), .BPC(8),
    .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
    .FIFO_DEPTH(64), .START_THRESH(16), .BG_COLOR(24'hFFFFFF)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_win_x(cfg_win_x), .cfg_win_y(cfg_win_y), .cfg_win_w(cfg_win_w), .cfg_win_h(cfg_win_h),
    .cfg_blank(cfg_blank),
    .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid), .in_ready(in_ready),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de), .out_data(out_data),
    .frame_cnt(frame_cnt), .stat_state(stat_state), .stat_fifo_level(stat_fifo_level),
    .stat_underflow_cnt(stat_underflow_cnt), .stat_misalign_cnt(stat_misalign_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        sof;
    logic [47:0] data;
  } beat_t;

  beat_t       src_q[$];
  logic [47:0] de_q[$];
  bit          drv_en;
  int          n_pass, n_fail, n_total;
  int          cyc, last_rise, hs_period;
  logic        hs_prev;

  function automatic logic [47:0] mk_beat(int f, int k);
    return {8'(f), 8'(k), 8'h5A, 8'(k), 8'(f), 8'hA5};
  endfunction

  task automatic add_frame(int f, int n);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.sof  = (k == 0);
      b.data = mk_beat(f, k);
      src_q.push_back(b);
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // one frame of de beats against a hand-built expectation
  task automatic check_frame(string tag, bit full, int src, int n_src, bit blank);
    int k;
    logic [47:0] expv, obs;
    k = 0;
    chk({tag, "_de_cnt"}, 64'(de_q.size()), 64'd32);
    for (int d = 0; d < 32; d++) begin
      int x, y;
      bit inw;
      x = d % 8;
      y = d / 8;
      inw = full || (x >= 2 && x < 6 && y >= 1 && y < 3);
      if (inw && k < n_src) begin
        expv = mk_beat(src, k);
        k++;
      end else begin
        expv = BG2;
      end
      if (blank) expv = 48'h0;
      obs = (d < de_q.size()) ? de_q[d] : 48'h0;
      chk($sformatf("%s_px%0d", tag, d), 64'(obs), 64'(expv));
    end
    $display("frame %s: de=%0d state=%0d level=%0d frames=%0d", tag, de_q.size(),
             stat_state, stat_fifo_level, frame_cnt);
    de_q.delete();
  endtask

  // source driver: holds a beat until accepted
  initial begin
    bit fire;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    forever begin
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fire && src_q.size() > 0) void'(src_q.pop_front());
      if (drv_en && src_q.size() > 0) begin
        in_valid = 1'b1;
        in_sof   = src_q[0].sof;
        in_data  = src_q[0].data;
      end else begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
      end
    end
  end

  // output monitor: collects de beats and the hs period
  initial begin
    cyc = 0; last_rise = -1; hs_period = 0; hs_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_de) de_q.push_back(out_data);
      if (out_hs && !hs_prev) begin
        if (last_rise >= 0) hs_period = cyc - last_rise;
        last_rise = cyc;
      end
      hs_prev = out_hs;
    end
  end

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    drv_en = 1'b0;
    rst = 1'b1;
    cfg_win_x = 12'd0; cfg_win_y = 12'd0; cfg_win_w = 12'd8; cfg_win_h = 12'd4;
    cfg_blank = 1'b0;
    add_frame(0, 32); add_frame(1, 32); add_frame(2, 8); add_frame(3, 8); add_frame(4, 3);

    // T1 reset state
    repeat (3) @(negedge clk);
    chk("rst_hs", 64'(out_hs), 64'd0);
    chk("rst_vs", 64'(out_vs), 64'd0);
    chk("rst_de", 64'(out_de), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_state", 64'(stat_state), 64'd0);
    chk("rst_frames", 64'(frame_cnt), 64'd0);
    chk("rst_level", 64'(stat_fifo_level), 64'd0);
    chk("rst_uf", 64'(stat_underflow_cnt), 64'd0);
    chk("rst_ma", 64'(stat_misalign_cnt), 64'd0);
    rst = 1'b0;
    drv_en = 1'b1;

    // two-clock latency from counters to outputs
    @(negedge clk);
    chk("lat_hs_1clk", 64'(out_hs), 64'd0);
    @(negedge clk);
    chk("lat_hs_2clk", 64'(out_hs), 64'd1);
    chk("lat_vs_2clk", 64'(out_vs), 64'd1);
    repeat (FR - 2) @(negedge clk);

    // T2 frame 0 in FILL: background only; FIFO stops at DEPTH-2
    check_frame("f0", 1, 0, 0, 0);
    chk("f0_state", 64'(stat_state), 64'd1);
    chk("f0_frames", 64'(frame_cnt), 64'd1);
    chk("f0_level", 64'(stat_fifo_level), 64'd62);
    chk("f0_ready", 64'(in_ready), 64'd0);

    repeat (FR) @(negedge clk);
    check_frame("f1", 1, 0, 32, 0);
    chk("f1_state", 64'(stat_state), 64'd2);
    chk("f1_frames", 64'(frame_cnt), 64'd2);
    chk("hs_period", 64'(hs_period), 64'd14);

    // T3 window change mid-frame only takes effect next frame
    repeat (10) @(negedge clk);
    cfg_win_x = 12'd2; cfg_win_w = 12'd4; cfg_win_y = 12'd1; cfg_win_h = 12'd2;
    repeat (FR - 10) @(negedge clk);
    check_frame("f2", 1, 1, 32, 0);
    chk("f2_frames", 64'(frame_cnt), 64'd3);

    // T6 blank requested mid-frame 3
    repeat (10) @(negedge clk);
    cfg_blank = 1'b1;
    repeat (FR - 10) @(negedge clk);
    check_frame("f3", 0, 2, 8, 0);
    chk("f3_level", 64'(stat_fifo_level), 64'd11);

    repeat (10) @(negedge clk);
    cfg_blank = 1'b0;
    repeat (FR - 10) @(negedge clk);
    check_frame("f4", 0, 3, 8, 1);
    chk("f4_level_popped", 64'(stat_fifo_level), 64'd3);
    chk("f4_state", 64'(stat_state), 64'd2);

    // T4 underflow after 3 beats of frame 4
    repeat (FR) @(negedge clk);
    check_frame("f5", 0, 4, 3, 0);
    chk("uf_cnt", 64'(stat_underflow_cnt), 64'd1);
    chk("uf_state", 64'(stat_state), 64'd0);
    chk("uf_level", 64'(stat_fifo_level), 64'd0);
    add_frame(5, 8); add_frame(6, 7); add_frame(7, 8);

    repeat (FR) @(negedge clk);
    check_frame("f6", 0, 0, 0, 0);
    chk("f6_state", 64'(stat_state), 64'd1);
    chk("f6_level", 64'(stat_fifo_level), 64'd23);

    repeat (FR) @(negedge clk);
    check_frame("f7", 0, 5, 8, 0);
    chk("f7_state", 64'(stat_state), 64'd2);
    chk("f7_level", 64'(stat_fifo_level), 64'd15);

    // T5 frame 6 is one beat short: sof of frame 7 seen mid-window
    repeat (FR) @(negedge clk);
    check_frame("f8", 0, 6, 7, 0);
    chk("ma_cnt", 64'(stat_misalign_cnt), 64'd1);
    chk("ma_state", 64'(stat_state), 64'd0);
    chk("ma_level", 64'(stat_fifo_level), 64'd0);
    chk("ma_uf_cnt", 64'(stat_underflow_cnt), 64'd1);
    add_frame(8, 8); add_frame(9, 8);

    repeat (FR) @(negedge clk);
    check_frame("f9", 0, 0, 0, 0);
    chk("f9_state", 64'(stat_state), 64'd1);
    chk("f9_level", 64'(stat_fifo_level), 64'd16);

    repeat (FR) @(negedge clk);
    check_frame("f10", 0, 8, 8, 0);
    chk("f10_state", 64'(stat_state), 64'd2);
    chk("f10_level", 64'(stat_fifo_level), 64'd8);
    chk("f10_frames", 64'(frame_cnt), 64'd11);

    // asynchronous reset mid-cycle, no clock edge in between
    #3 rst = 1'b1;
    #1;
    chk("arst_de", 64'(out_de), 64'd0);
    chk("arst_hs", 64'(out_hs), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_state", 64'(stat_state), 64'd0);
    chk("arst_level", 64'(stat_fifo_level), 64'd0);
    chk("arst_frames", 64'(frame_cnt), 64'd0);
    chk("arst_uf", 64'(stat_underflow_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
